// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin encoder arbiter.
package arb_pkg;

    localparam int ARB_N    = 8;
    localparam int ARB_IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_encoder_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_encoder_arbiter_if;
    import arb_pkg::*;

    logic [ARB_N-1:0]    req;
    logic                done;
    logic [ARB_N-1:0]    gnt;
    logic [ARB_IDXW-1:0] gnt_idx;
    logic                gnt_valid;
    logic                timeout;

    // Requester side: raises requests and the release strobe.
    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    // Arbiter side.
    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface : rr_encoder_arbiter_if

// File: rtl/rr_pick.sv
// Rotating priority picker: first set request at or after base, wrapping 7->0.
module rr_pick
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]    req,
    input  logic [ARB_IDXW-1:0] base,
    output logic                any,
    output logic [ARB_IDXW-1:0] idx,
    output logic [ARB_N-1:0]    onehot
);

    logic [ARB_N-1:0]    rot;
    logic [ARB_IDXW-1:0] enc;

    // Rotate so base sits at bit 0, take the lowest set bit, rotate the index back.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        rot    = ARB_N'({req, req} >> base);
        enc    = '0;
        any    = |req;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            if (rot[i]) enc = ARB_IDXW'(i);
        end
        idx    = enc + base;
        onehot = any ? (ARB_N'(1) << idx) : '0;
    end

endmodule : rr_pick

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter with one-hot + encoded grant, release on done/withdrawal/timeout.
module rr_encoder_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_encoder_arbiter_if.slave  bus
);

    localparam int                CW        = $clog2(MAX_HOLD);
    localparam logic [CW-1:0]     HOLD_LAST = CW'(MAX_HOLD - 1);

    arb_state_t          state_q, state_d;
    logic [ARB_IDXW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]       hold_q, hold_d;
    logic [ARB_N-1:0]    gnt_q, gnt_d;
    logic [ARB_IDXW-1:0] idx_q, idx_d;
    logic                valid_q, valid_d;
    logic                timeout_q, timeout_d;

    logic                pick_any;
    logic [ARB_IDXW-1:0] pick_idx;
    logic [ARB_N-1:0]    pick_onehot;
    logic                expired;

    rr_pick u_pick (
        .req    (bus.req),
        .base   (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign expired = (hold_q == HOLD_LAST);

    // Next-state and next-output logic; done outranks the timeout pulse.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = pick_onehot;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (bus.done || !bus.req[idx_q] || expired) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    idx_d     = '0;
                    valid_d   = 1'b0;
                    ptr_d     = idx_q + ARB_IDXW'(1);
                    timeout_d = expired && !bus.done;
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = timeout_q;

endmodule : rr_encoder_arbiter

// File: tb/tb_rr_encoder_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_rr_encoder_arbiter;

    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst;

    rr_encoder_arbiter_if bus ();

    rr_encoder_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Model: current owner (-1 when idle), next scan start, cycles the grant has been visible.
    int owner = -1;
    int mptr  = 0;
    int held  = 0;
    bit mto   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_gnt();
        return (owner < 0) ? 8'h00 : 8'(1 << owner);
    endfunction

    // Reference behaviour, evaluated from the inputs seen at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            owner = -1; mptr = 0; held = 0; mto = 1'b0;
        end else if (owner < 0) begin
            mto = 1'b0;
            for (int off = 0; off < 8; off++) begin
                int k;
                k = (mptr + off) % 8;
                if (bus.req[k]) begin
                    owner = k;
                    held  = 1;
                    break;
                end
            end
        end else begin
            if (bus.done || !bus.req[owner] || held == MAX_HOLD) begin
                mto   = !bus.done && (held == MAX_HOLD);
                mptr  = (owner + 1) % 8;
                owner = -1;
                held  = 0;
            end else begin
                mto  = 1'b0;
                held = held + 1;
            end
        end
    end

    // Compare every output against the model every cycle once reset has been applied.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("gnt",       32'(bus.gnt),       32'(exp_gnt()));
            check("gnt_idx",   32'(bus.gnt_idx),   (owner < 0) ? 32'd0 : 32'(owner));
            check("gnt_valid", 32'(bus.gnt_valid), 32'(owner >= 0));
            check("timeout",   32'(bus.timeout),   32'(mto));
            check("valid_eq_or", 32'(bus.gnt_valid), 32'(|bus.gnt));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; bus.req = 8'hFF; bus.done = 1'b0;

        // Reset held two cycles with all requests high.
        tick(); cmp_en = 1'b1;
        tick();
        check("rst_gnt", 32'(bus.gnt), 32'h00);
        check("rst_valid", 32'(bus.gnt_valid), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        rst = 1'b0;
        tick();
        check("first_gnt", 32'(bus.gnt), 32'h01);
        check("first_idx", 32'(bus.gnt_idx), 32'd0);

        // Rotation 0..7,0 with one dead cycle between grants.
        for (int i = 1; i <= 8; i++) begin
            bus.done = 1'b1; tick();
            check("rot_dead", 32'(bus.gnt_valid), 32'd0);
            bus.done = 1'b0; tick();
            check("rot_idx", 32'(bus.gnt_idx), 32'(i % 8));
        end
        bus.done = 1'b1; tick(); bus.done = 1'b0;

        // Skip and wrap: grant 5 then release leaves ptr at 6.
        bus.req = 8'h00; tick();
        bus.req = 8'h20; tick();
        check("skip_idx5", 32'(bus.gnt_idx), 32'd5);
        bus.done = 1'b1; bus.req = 8'h05; tick();
        bus.done = 1'b0; tick();
        check("wrap_idx0", 32'(bus.gnt_idx), 32'd0);
        bus.done = 1'b1; tick();
        bus.done = 1'b0; tick();
        check("skip_idx2", 32'(bus.gnt_idx), 32'd2);
        bus.done = 1'b1; tick(); bus.done = 1'b0;

        // Timeout: four cycles of grant, one timeout cycle, then re-grant.
        bus.req = 8'h00; tick();
        bus.req = 8'h10;
        for (int c = 0; c < MAX_HOLD; c++) begin
            tick();
            check("to_valid", 32'(bus.gnt_valid), 32'd1);
            check("to_idx", 32'(bus.gnt_idx), 32'd4);
        end
        tick();
        check("to_pulse", 32'(bus.timeout), 32'd1);
        check("to_idle", 32'(bus.gnt_valid), 32'd0);
        tick();
        check("to_regrant", 32'(bus.gnt), 32'h10);
        check("to_pulse_end", 32'(bus.timeout), 32'd0);

        // Withdrawal by owner 3 releases without timeout.
        bus.req = 8'h00; tick(); tick();
        bus.req = 8'h08; tick();
        check("wd_idx3", 32'(bus.gnt_idx), 32'd3);
        bus.req = 8'h00; tick();
        check("wd_released", 32'(bus.gnt_valid), 32'd0);
        check("wd_no_to", 32'(bus.timeout), 32'd0);

        // done on the timeout cycle suppresses the pulse.
        bus.req = 8'h08; tick();
        tick(); tick(); tick();
        bus.done = 1'b1; tick();
        check("done_to_valid", 32'(bus.gnt_valid), 32'd0);
        check("done_to_pulse", 32'(bus.timeout), 32'd0);
        bus.done = 1'b0;

        // Mid-grant reset restores the pointer to 0.
        bus.req = 8'h20; tick();
        check("mr_idx5", 32'(bus.gnt_idx), 32'd5);
        rst = 1'b1; bus.req = 8'hFF; tick();
        check("mr_gnt", 32'(bus.gnt), 32'h00);
        rst = 1'b0; tick();
        check("mr_idx0", 32'(bus.gnt), 32'h01);

        // Random traffic; requests change only occasionally so grants persist.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0) bus.req = 8'($urandom & $urandom);
                else                           bus.req = 8'($urandom);
            end
            bus.done = ($urandom_range(0, 4) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rr_encoder_arbiter
